ls_sequencer: RTL and testbench

LS_SEQUENCER -- requirements
Module: ls_sequencer

---
 rtl/ls_seq_pkg.sv | 19 +
 rtl/ls_timeout_ctr.sv | 31 +++
 rtl/ls_sequencer.sv | 146 ++++++++++++++
 tb/tb_ls_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_seq_pkg.sv
// Shared constants for the load/store sequencer: opcodes, FSM encoding, default widths.
package ls_seq_pkg;

  localparam int unsigned DefAddrW   = 8;
  localparam int unsigned DefDataW   = 16;
  localparam int unsigned DefRegAw   = 3;
  localparam int unsigned DefTimeout = 15;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b11;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLdWait = 2'd1,
    StLdWb   = 2'd2,
    StStWait = 2'd3
  } state_e;

endpackage

// File: rtl/ls_timeout_ctr.sv
// Wait-cycle counter: cleared on entry to a wait state, counts un-acked cycles and
// saturates at TIMEOUT, where expired is raised.
module ls_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Clear has priority; stop counting once the limit is hit
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                 cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + CNT_W'(1);
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/ls_sequencer.sv
// Load/store sequencer: accepts one instruction at a time, issues a single memory request,
// writes load data back to the register file and reports done / illegal / timeout pulses.
// Store done, illegal and timeout pulses are registered and appear the cycle after the event.
module ls_sequencer
  import ls_seq_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned REG_AW  = DefRegAw,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        opcode,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic [REG_AW-1:0] instr_reg,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_timeout
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REG_AW-1:0] reg_q, reg_d;
  logic [DATA_W-1:0] data_q, data_d;  // store data on accept, load data on ack
  logic              st_done_q, st_done_d;
  logic              err_ill_q, err_ill_d;
  logic              err_to_q, err_to_d;

  logic accept, is_load, is_store, in_wait, expired;

  assign accept   = instr_valid & instr_ready;
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign in_wait  = (state_q == StLdWait) || (state_q == StStWait);

  ls_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (8)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .en      (in_wait & ~mem_ack),
    .expired (expired)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      reg_q     <= '0;
      data_q    <= '0;
      st_done_q <= 1'b0;
      err_ill_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      st_done_q <= st_done_d;
      err_ill_q <= err_ill_d;
      err_to_q  <= err_to_d;
    end
  end

  // Next-state, field latching and pulse generation
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    reg_d     = reg_q;
    data_d    = data_q;
    st_done_d = 1'b0;
    err_ill_d = 1'b0;
    err_to_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_load || is_store) begin
            addr_d  = instr_addr;
            reg_d   = instr_reg;
            state_d = is_load ? StLdWait : StStWait;
            if (is_store) data_d = rf_rdata;
          end else begin
            err_ill_d = 1'b1;
          end
        end
      end
      StLdWait: begin
        // Ack on the expiry cycle still counts as success
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = StLdWb;
        end else if (expired) begin
          err_to_d = 1'b1;
          state_d  = StIdle;
        end
      end
      StLdWb: state_d = StIdle;
      StStWait: begin
        if (mem_ack) begin
          st_done_d = 1'b1;
          state_d   = StIdle;
        end else if (expired) begin
          err_to_d = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state and latched fields
  always_comb begin
    instr_ready = (state_q == StIdle) && rst_n;
    busy        = (state_q != StIdle);
    mem_req     = in_wait;
    mem_we      = (state_q == StStWait);
    mem_addr    = addr_q;
    mem_wdata   = data_q;
    rf_raddr    = (state_q == StIdle) ? instr_reg : reg_q;
    rf_we       = (state_q == StLdWb);
    rf_waddr    = reg_q;
    rf_wdata    = data_q;
    done        = (state_q == StLdWb) || st_done_q;
    err_illegal = err_ill_q;
    err_timeout = err_to_q;
  end

endmodule

// File: tb/tb_ls_sequencer.sv
// Directed bench for ls_sequencer: load, store, illegal, stray ack, timeout, late ack,
// reset abort and back-to-back issue, each step checked against hand-computed values.
module tb_ls_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  opcode;
  logic [7:0]  instr_addr;
  logic [2:0]  instr_reg;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        busy, done, err_illegal, err_timeout;

  logic [15:0] rf [8];
  assign rf_rdata = rf[rf_raddr];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ls_sequencer #(
    .ADDR_W  (8),
    .DATA_W  (16),
    .REG_AW  (3),
    .TIMEOUT (15)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .instr_addr  (instr_addr),
    .instr_reg   (instr_reg),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy        (busy),
    .done        (done),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [2:0] r);
    instr_valid = 1'b1;
    opcode      = op;
    instr_addr  = a;
    instr_reg   = r;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h0100 + 16'(i);
    rf[5] = 16'h1234;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    opcode      = 2'b00;
    instr_addr  = '0;
    instr_reg   = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;

    // Reset state
    #1;
    chk("rst_ready", instr_ready, 0);
    chk("rst_outs", {mem_req, mem_we, rf_we, done, err_illegal, err_timeout, busy}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_ready", instr_ready, 1);
    chk("rel_busy", busy, 0);

    // Load 0x12 -> r3, ack after two wait cycles with 0xBEEF
    issue(2'b00, 8'h12, 3'd3);
    #1;
    chk("ld_raddr", rf_raddr, 3);
    tick();
    instr_valid = 1'b0;
    #1;
    chk("ld_req", {mem_req, mem_we, busy, instr_ready}, 4'b1010);
    chk("ld_addr", mem_addr, 8'h12);
    tick();
    chk("ld_req2", mem_req, 1);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    #1;
    chk("ld_req3", mem_req, 1);
    chk("ld_no_we_yet", rf_we, 0);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'h0000;
    #1;
    chk("ld_wb", {rf_we, done, mem_req}, 3'b110);
    chk("ld_waddr", rf_waddr, 3);
    chk("ld_wdata", rf_wdata, 16'hBEEF);
    tick();
    chk("ld_after", {rf_we, done, busy, instr_ready}, 4'b0001);

    // Store r5 (0x1234) to 0x40 with immediate ack
    issue(2'b11, 8'h40, 3'd5);
    tick();
    instr_valid = 1'b0;
    mem_ack     = 1'b1;
    #1;
    chk("st_req", {mem_req, mem_we, rf_we, done}, 4'b1100);
    chk("st_addr", mem_addr, 8'h40);
    chk("st_wdata", mem_wdata, 16'h1234);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("st_done", {done, rf_we, mem_req, busy}, 4'b1000);
    tick();
    chk("st_after", {done, rf_we}, 2'b00);

    // Illegal opcode 01
    issue(2'b01, 8'h77, 3'd2);
    tick();
    instr_valid = 1'b0;
    #1;
    chk("ill_pulse", {err_illegal, mem_req, busy, instr_ready}, 4'b1001);
    tick();
    chk("ill_clear", {err_illegal, mem_req, busy, rf_we}, 4'b0000);

    // Stray ack while idle has no effect
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("stray_ack", {busy, done, rf_we, mem_req, err_timeout}, 5'b00000);

    // Load with no ack: 16 wait cycles (count 0..15), then timeout pulse
    issue(2'b00, 8'h21, 3'd1);
    for (int i = 0; i < 16; i++) begin
      tick();
      instr_valid = 1'b0;
      #1;
      chk("to_wait", {mem_req, err_timeout}, 2'b10);
    end
    tick();
    chk("to_pulse", {err_timeout, rf_we, done, busy, mem_req}, 5'b10000);
    tick();
    chk("to_clear", err_timeout, 0);

    // Same load with ack on the final wait cycle: success
    issue(2'b00, 8'h21, 3'd1);
    for (int i = 0; i < 16; i++) begin
      tick();
      instr_valid = 1'b0;
      if (i == 15) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hA5A5;
      end
      #1;
      chk("late_wait", mem_req, 1);
    end
    tick();
    mem_ack = 1'b0;
    #1;
    chk("late_wb", {rf_we, done, err_timeout}, 3'b110);
    chk("late_wdata", rf_wdata, 16'hA5A5);
    chk("late_waddr", rf_waddr, 1);
    tick();
    chk("late_no_to", {err_timeout, rf_we}, 2'b00);

    // Reset during LD_WAIT abandons the load
    issue(2'b00, 8'h33, 3'd4);
    tick();
    instr_valid = 1'b0;
    #1;
    chk("rab_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rab_drop", {mem_req, busy, instr_ready}, 3'b000);
    tick();
    tick();
    rst_n   = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_ack = 1'b0;
      #1;
      chk("rab_quiet", {rf_we, done, err_timeout, err_illegal, busy}, 5'b00000);
    end

    // Back-to-back: load then store with instr_valid held
    issue(2'b00, 8'h50, 3'd6);
    tick();
    issue(2'b11, 8'h60, 3'd5);
    mem_ack   = 1'b1;
    mem_rdata = 16'h1111;
    #1;
    chk("b2b_ld", {instr_ready, mem_req, mem_we}, 3'b010);
    chk("b2b_ld_addr", mem_addr, 8'h50);
    tick();
    mem_ack = 1'b0;
    #1;
    chk("b2b_wb", {rf_we, done, instr_ready}, 3'b110);
    chk("b2b_wb_data", {rf_waddr, rf_wdata}, {3'd6, 16'h1111});
    tick();
    chk("b2b_accept", {instr_ready, busy}, 2'b10);
    chk("b2b_raddr", rf_raddr, 5);
    tick();
    instr_valid = 1'b0;
    mem_ack     = 1'b1;
    #1;
    chk("b2b_st", {mem_req, mem_we}, 2'b11);
    chk("b2b_st_data", {mem_addr, mem_wdata}, {8'h60, 16'h1234});
    tick();
    mem_ack = 1'b0;
    #1;
    chk("b2b_st_done", {done, rf_we, busy}, 3'b100);
    tick();
    chk("b2b_end", {done, busy, instr_ready}, 3'b001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
